// File: rtl/md_pad_pkg.sv
// Shared Mega Drive pad definitions: button indices, phase codes, line order.
// pad_lines() is the single source of truth for what each phase puts on D5..D0.
package md_pad_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam logic [2:0] PH_IDLE_H = 3'd0;
    localparam logic [2:0] PH_ID     = 3'd5;
    localparam logic [2:0] PH_EXT    = 3'd6;

    localparam int D0 = 0;
    localparam int D1 = 1;
    localparam int D2 = 2;
    localparam int D3 = 3;
    localparam int D4 = 4;
    localparam int D5 = 5;

    // Active-low line image for a phase; 0 = driven low, 1 = released.
    function automatic logic [5:0] pad_lines(input logic [2:0] ph, input logic [11:0] btn);
        logic [5:0] lines;
        lines = '1;
        if (ph[0]) begin
            lines[D4] = ~btn[BTN_A];
            lines[D5] = ~btn[BTN_START];
        end else begin
            lines[D4] = ~btn[BTN_B];
            lines[D5] = ~btn[BTN_C];
        end
        case (ph)
            3'd1, 3'd3: begin
                lines[D0] = ~btn[BTN_U];
                lines[D1] = ~btn[BTN_D];
                lines[D2] = 1'b0;
                lines[D3] = 1'b0;
            end
            PH_ID: begin
                lines[D0] = 1'b0;
                lines[D1] = 1'b0;
                lines[D2] = 1'b0;
                lines[D3] = 1'b0;
            end
            PH_EXT: begin
                lines[D0] = ~btn[BTN_Z];
                lines[D1] = ~btn[BTN_Y];
                lines[D2] = ~btn[BTN_X];
                lines[D3] = ~btn[BTN_MODE];
            end
            3'd7: ;
            default: begin
                lines[D0] = ~btn[BTN_U];
                lines[D1] = ~btn[BTN_D];
                lines[D2] = ~btn[BTN_L];
                lines[D3] = ~btn[BTN_R];
            end
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/md_pad_responder_if.sv
// Pad-side bundle between a DB9 host (master) and the pad responder (slave).
// Host drives select, mode and button image; responder returns lines and debug state.
interface md_pad_responder_if;
    logic        pad_sel;
    logic        six_btn_en;
    logic [11:0] buttons;
    logic [5:0]  pad_out;
    logic [2:0]  phase;
    logic        id_strobe;

    modport master (output pad_sel, six_btn_en, buttons, input pad_out, phase, id_strobe);
    modport slave  (input pad_sel, six_btn_en, buttons, output pad_out, phase, id_strobe);
endinterface

// File: rtl/md_sel_sync.sv
// Synchronizes the asynchronous select line and flags each level change.
// Latency SYNC_STAGES cycles to sel_s, edge flagged in the cycle sel_s changes; no backpressure.
module md_sel_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic sel_a,
    output logic sel_s,
    output logic sel_edge
);
    logic [STAGES-1:0] sync_q;
    logic              sel_d;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '1;
            sel_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sel_a};
            sel_d  <= sync_q[STAGES-1];
        end
    end

    assign sel_s    = sync_q[STAGES-1];
    assign sel_edge = sel_s ^ sel_d;
endmodule

// File: rtl/md_pad_responder.sv
// Mega Drive pad device side: tracks the host's select phase and drives D5..D0.
// Select edge to pad_out in SYNC_STAGES+2 cycles, buttons in 1; host cannot be stalled.
module md_pad_responder
    import md_pad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 18000,
    parameter int SYNC_STAGES    = 2
) (
    input logic               clk_sys,
    input logic               RESET_N,
    md_pad_responder_if.slave pad
);
    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          sel_s;
    logic          sel_edge;
    logic [2:0]    phase_q, phase_nxt, sel_ph;
    logic [CW-1:0] tmo_cnt, tmo_nxt;
    logic [5:0]    pad_out_q;
    logic          strobe_q;

    md_sel_sync #(.STAGES(SYNC_STAGES)) u_sel_sync (
        .clk_sys  (clk_sys),
        .RESET_N  (RESET_N),
        .sel_a    (pad.pad_sel),
        .sel_s    (sel_s),
        .sel_edge (sel_edge)
    );

    // Edge increment beats both the timeout and the parity resync.
    always_comb begin
        phase_nxt = phase_q;
        tmo_nxt   = tmo_cnt;
        sel_ph    = {2'b00, ~sel_s};
        if (sel_edge) begin
            tmo_nxt = '0;
        end else if (tmo_cnt != TMO_LAST) begin
            tmo_nxt = tmo_cnt + 1'b1;
        end
        if (!pad.six_btn_en) begin
            phase_nxt = sel_ph;
        end else if (sel_edge) begin
            phase_nxt = phase_q + 3'd1;
        end else if (tmo_cnt == TMO_LAST || phase_q[0] == sel_s) begin
            phase_nxt = sel_ph;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q   <= PH_IDLE_H;
            tmo_cnt   <= '0;
            pad_out_q <= 6'h3F;
            strobe_q  <= 1'b0;
        end else begin
            phase_q   <= phase_nxt;
            tmo_cnt   <= tmo_nxt;
            pad_out_q <= pad_lines(phase_q, pad.buttons);
            strobe_q  <= (phase_q == 3'd4) && (phase_nxt == PH_ID);
        end
    end

    assign pad.pad_out   = pad_out_q;
    assign pad.phase     = phase_q;
    assign pad.id_strobe = strobe_q;
endmodule

// File: tb/tb_md_pad_responder.sv
// Bench for md_pad_responder: directed protocol cases then random select/button traffic
// checked against a transaction-level phase model.
module tb_md_pad_responder;
    localparam int TMO = 300;
    localparam int LO  = -1;
    localparam int HI  = -2;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    md_pad_responder_if pif();

    md_pad_responder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clk_sys (clk_sys),
        .RESET_N (rst_n),
        .pad     (pif)
    );

    int n_chk = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int exp_strobe = 0;
    int m_phase;
    logic m_sel;
    logic m_en;
    int m_idle;

    always @(negedge clk_sys) if (pif.id_strobe === 1'b1) n_strobe++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line source per phase: button index, or LO/HI for fixed levels.
    function automatic logic [5:0] exp_pad(input int ph, input logic [11:0] b);
        int src[6];
        logic [5:0] r;
        case (ph)
            0, 2, 4: src = '{3, 2, 1, 0, 4, 5};
            1, 3:    src = '{3, 2, LO, LO, 6, 7};
            5:       src = '{LO, LO, LO, LO, 6, 7};
            6:       src = '{11, 10, 9, 8, 4, 5};
            default: src = '{HI, HI, HI, HI, 6, 7};
        endcase
        for (int i = 0; i < 6; i++) begin
            if (src[i] == LO)      r[i] = 1'b0;
            else if (src[i] == HI) r[i] = 1'b1;
            else                   r[i] = ~b[src[i]];
        end
        return r;
    endfunction

    task automatic expect_state(input string tag);
        chk({tag, "_ph"}, 32'(pif.phase), 32'(m_phase));
        chk({tag, "_pad"}, 32'(pif.pad_out), 32'(exp_pad(m_phase, pif.buttons)));
    endtask

    task automatic sel_step(input logic v, input int w);
        @(negedge clk_sys);
        pif.pad_sel = v;
        if (m_en) begin
            if (v != m_sel) begin
                if (m_phase == 4) exp_strobe++;
                m_phase = (m_phase + 1) % 8;
            end
        end else begin
            m_phase = v ? 0 : 1;
        end
        if (v != m_sel) m_idle = w; else m_idle += w;
        m_sel = v;
        repeat (w) @(negedge clk_sys);
    endtask

    initial begin
        int s0;
        int r;
        int w;
        pif.pad_sel = 1'b1;
        pif.six_btn_en = 1'b0;
        pif.buttons = 12'h000;
        m_phase = 0; m_sel = 1'b1; m_en = 1'b0; m_idle = 0;

        repeat (3) @(negedge clk_sys);
        chk("rst_pad", 32'(pif.pad_out), 32'h3F);
        chk("rst_ph", 32'(pif.phase), 0);
        chk("rst_strobe", 32'(pif.id_strobe), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("post_rst_pad", 32'(pif.pad_out), 32'h3F);
        chk("post_rst_ph", 32'(pif.phase), 0);

        // 3-button mode, exact select-to-output latency
        pif.buttons = 12'h048;
        repeat (2) @(negedge clk_sys);
        chk("b3_hi", 32'(pif.pad_out), 32'b111110);
        pif.pad_sel = 1'b0; m_sel = 1'b0; m_phase = 1;
        repeat (3) @(negedge clk_sys);
        chk("b3_lat_early", 32'(pif.pad_out), 32'b111110);
        @(negedge clk_sys);
        chk("b3_lat", 32'(pif.pad_out), 32'b100010);
        chk("b3_ph", 32'(pif.phase), 1);

        // 6-button sequence through ID, extended and trailing phases
        sel_step(1'b1, 20);
        pif.six_btn_en = 1'b1; m_en = 1'b1;
        pif.buttons = 12'h980;
        repeat (5) @(negedge clk_sys);
        sel_step(1'b0, 20); sel_step(1'b1, 20); sel_step(1'b0, 20); sel_step(1'b1, 20);
        s0 = n_strobe;
        sel_step(1'b0, 20);
        chk("b6_ph5_pad", 32'(pif.pad_out), 32'b010000);
        chk("b6_ph5_strobe", 32'(n_strobe - s0), 1);
        expect_state("b6_ph5");
        sel_step(1'b1, 20);
        chk("b6_ph6_pad", 32'(pif.pad_out), 32'b110110);
        sel_step(1'b0, 20);
        chk("b6_ph7_pad", 32'(pif.pad_out), 32'b011111);
        chk("b6_ph7_ph", 32'(pif.phase), 7);
        sel_step(1'b1, 20);
        expect_state("b6_wrap");

        // timeout from phase 6, checked on both sides of the terminal count
        while (m_phase != 5) sel_step(~m_sel, 12);
        pif.buttons = 12'h02C;
        @(negedge clk_sys);
        pif.pad_sel = 1'b1; m_sel = 1'b1; m_phase = 6;
        repeat (TMO + 2) @(negedge clk_sys);
        chk("tmo_before", 32'(pif.phase), 6);
        @(negedge clk_sys);
        chk("tmo_after", 32'(pif.phase), 0);
        @(negedge clk_sys);
        m_phase = 0;
        chk("tmo_pad", 32'(pif.pad_out), 32'b011100);
        expect_state("tmo");

        // edge landing on the terminal count still increments
        m_idle = TMO + 20;
        while (m_phase != 5) sel_step(~m_sel, 12);
        pif.pad_sel = 1'b1; m_sel = 1'b1; m_phase = 6;
        repeat (TMO) @(negedge clk_sys);
        pif.pad_sel = 1'b0; m_sel = 1'b0; m_phase = 7;
        repeat (10) @(negedge clk_sys);
        chk("coinc_ph", 32'(pif.phase), 7);
        repeat (40) @(negedge clk_sys);
        chk("coinc_hold", 32'(pif.phase), 7);
        m_idle = 50;

        // drop 6-button mode while in the ID phase
        while (m_phase != 5) sel_step(~m_sel, 12);
        pif.buttons = 12'h008;
        expect_state("drop_pre");
        pif.six_btn_en = 1'b0; m_en = 1'b0; m_phase = 1;
        @(negedge clk_sys);
        chk("drop_ph", 32'(pif.phase), 1);
        @(negedge clk_sys);
        chk("drop_d32", 32'(pif.pad_out[3:2]), 0);
        chk("drop_d10", 32'(pif.pad_out[1:0]), 32'b10);

        // asynchronous reset in phase 6
        pif.six_btn_en = 1'b1; m_en = 1'b1;
        repeat (3) @(negedge clk_sys);
        while (m_phase != 6) sel_step(~m_sel, 12);
        @(posedge clk_sys);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pad", 32'(pif.pad_out), 32'h3F);
        chk("arst_ph", 32'(pif.phase), 0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        m_phase = 0; m_idle = 0;
        repeat (4) @(negedge clk_sys);
        sel_step(1'b0, 20);
        chk("arst_pulse_ph", 32'(pif.phase), 1);

        // random traffic
        for (int step = 0; step < 120; step++) begin
            r = $urandom_range(0, 19);
            w = $urandom_range(8, 40);
            pif.buttons = 12'($urandom);
            if (r == 0) begin
                repeat (TMO + 20) @(negedge clk_sys);
                m_idle += TMO + 20;
                if (m_en) m_phase = m_sel ? 0 : 1;
            end else if (r <= 2 && m_idle + 12 < TMO - 20) begin
                @(negedge clk_sys);
                pif.six_btn_en = ~m_en;
                m_en = ~m_en;
                if (!m_en) m_phase = m_sel ? 0 : 1;
                repeat (12) @(negedge clk_sys);
                m_idle += 13;
            end else if (r <= 5 && m_idle + 40 < TMO - 20) begin
                sel_step(m_sel, w);
            end else begin
                sel_step(~m_sel, w);
            end
            expect_state("rnd");
            chk("rnd_strobe", 32'(n_strobe), 32'(exp_strobe));
        end

        chk("strobe_total", 32'(n_strobe), 32'(exp_strobe));
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
